// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg
// Shared encodings for the EX-stage execute unit.
//   ALU_*  : 4-bit combinational ALU operation codes (existing MIPS150 set)
//   md_op_e: 3-bit multiply/divide unit operation codes
// Helpers classify md_op codes for the sequencer.
package alu_muldiv_pkg;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_LUI  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_NOR  = 4'd11;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  // Operations that run the iterative datapath and end with md_done.
  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_muldiv_seq.sv
// muldiv_seq
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, rst          clock, async active-high reset
//   A, B              operands, sampled on the accepting edge
//   md_op, md_valid   request (accepted when md_valid & md_ready)
//   md_ready          high while IDLE
//   md_done           one-cycle pulse when a MULT/DIV result lands in HI/LO
//   hi, lo            HI/LO registers
//
// state | meaning
// IDLE  | accepting requests; MTHI/MTLO complete here in one edge
// BUSY  | one shift-add or restoring-subtract step per cycle, WIDTH steps
// FIX   | sign-correct the magnitude result and write HI/LO
module muldiv_seq
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       md_op,
  input  logic             md_valid,
  output logic             md_ready,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;
  logic   start;

  logic [CNT_W-1:0] cnt;
  // acc: upper product half (multiply) or partial remainder (divide).
  // q:   multiplier shifting out / quotient shifting in.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic             is_div;
  logic             neg_p;
  logic             neg_r;
  logic             div_zero;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign md_ready = (state == S_IDLE);
  assign start    = md_valid && md_ready && md_is_long(md_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_BUSY;
      S_BUSY:  if (cnt == CNT_LAST) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operands are processed as magnitudes; signs are reapplied in FIX.
  always_comb begin
    a_neg = md_is_signed(md_op) & A[WIDTH-1];
    b_neg = md_is_signed(md_op) & B[WIDTH-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
  end

  always_comb begin
    mul_sum   = acc + (q[0] ? {1'b0, dvsr} : '0);
    div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
    // Bit WIDTH set means the trial subtraction went negative (restore).
    div_diff  = div_shift - {1'b0, dvsr};
  end

  always_comb begin
    prod_mag = {acc[WIDTH-1:0], q};
    prod     = neg_p ? -prod_mag : prod_mag;
    quo      = neg_p ? -q : q;
    rem      = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    res_hi   = prod[2*WIDTH-1:WIDTH];
    res_lo   = prod[WIDTH-1:0];
    if (is_div) begin
      // A zero divisor leaves the dividend in the remainder, so hi = A falls out
      // of the normal sign correction; only the quotient needs forcing.
      res_hi = rem;
      res_lo = div_zero ? '1 : quo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      md_done  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      dvsr     <= '0;
      is_div   <= 1'b0;
      neg_p    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (md_valid && md_ready) begin
            case (md_op)
              MD_MTHI: hi <= A;
              MD_MTLO: lo <= A;
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                is_div   <= md_is_div(md_op);
                neg_p    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (B == '0);
                dvsr     <= b_mag;
                acc      <= '0;
                q        <= a_mag;
                cnt      <= '0;
              end
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              acc <= div_diff;
              q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
              acc <= div_shift;
              q   <= {q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= {1'b0, mul_sum[WIDTH:1]};
            q   <= {mul_sum[0], q[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          hi      <= res_hi;
          lo      <= res_lo;
          md_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv
// EX-stage execute unit: combinational ALU plus iterative mul/div unit.
// Ports:
//   clk, rst          clock, async active-high reset
//   A, B              operands (rs; rt/immediate/shamt)
//   ALUop, Out        combinational ALU operation and result
//   md_op, md_valid   mul/div request; md_ready high when it can be accepted
//   md_done           one-cycle pulse when a MULT/DIV result lands in HI/LO
//   hi, lo            architectural HI/LO registers
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUop,
  output logic [WIDTH-1:0] Out,
  input  logic [2:0]       md_op,
  input  logic             md_valid,
  output logic             md_ready,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = B[SHAMT_W-1:0];

  always_comb begin
    Out = '0;
    case (ALUop)
      ALU_ADDU: Out = A + B;
      ALU_SUBU: Out = A - B;
      ALU_SLT:  Out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: Out = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_AND:  Out = A & B;
      ALU_OR:   Out = A | B;
      ALU_XOR:  Out = A ^ B;
      ALU_NOR:  Out = ~(A | B);
      ALU_SLL:  Out = A << shamt;
      ALU_SRL:  Out = A >> shamt;
      ALU_SRA:  Out = $unsigned($signed(A) >>> shamt);
      ALU_LUI:  Out = B << (WIDTH / 2);
      default:  Out = '0;
    endcase
  end

  muldiv_seq #(
    .WIDTH (WIDTH)
  ) u_muldiv_seq (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .md_op    (md_op),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_done  (md_done),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B, Out, hi, lo;
  logic [3:0]  ALUop;
  logic [2:0]  md_op;
  logic        md_valid, md_ready, md_done;

  logic [15:0] a16, b16, out16, hi16, lo16;
  logic [3:0]  alu16;
  logic [2:0]  op16;
  logic        valid16, ready16, done16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALUop(ALUop), .Out(Out),
    .md_op(md_op), .md_valid(md_valid), .md_ready(md_ready), .md_done(md_done),
    .hi(hi), .lo(lo)
  );

  alu_muldiv #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .A(a16), .B(b16), .ALUop(alu16), .Out(out16),
    .md_op(op16), .md_valid(valid16), .md_ready(ready16), .md_done(done16),
    .hi(hi16), .lo(lo16)
  );

  // Issue one 32-bit request and count edges after the accepting edge until md_done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output bit low_ok);
    @(negedge clk); md_op = op; A = a; B = b; md_valid = 1'b1;
    @(negedge clk); md_valid = 1'b0;
    low_ok = (md_ready == 1'b0);
    edges = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (md_done) begin edges = k; break; end
      if (md_ready) low_ok = 1'b0;
    end
  endtask

  task automatic run_op16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          output int edges);
    @(negedge clk); op16 = op; a16 = a; b16 = b; valid16 = 1'b1;
    @(negedge clk); valid16 = 1'b0;
    edges = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done16) begin edges = k; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", md_ready); end
    checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", md_done); end
    checks++; if (ready16 !== 1'b1 || hi16 !== 16'h0) begin errors++; $display("FAIL reset_w16: ready %b hi %h want 1 0000", ready16, hi16); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_alu();
    logic [3:0]  ops [13] = '{ALU_SLT, ALU_SLTU, ALU_SRA, ALU_SRL, ALU_LUI, ALU_ADDU, ALU_SUBU,
                              ALU_NOR, ALU_SLL, ALU_SRA, ALU_AND, ALU_XOR, 4'hE};
    logic [31:0] va  [13] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h0,
                              32'hFFFFFFFF, 32'h0, 32'h0F0F0000, 32'h1, 32'h40000000,
                              32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFFFFFF};
    logic [31:0] vb  [13] = '{32'h1, 32'h1, 32'h4, 32'h4, 32'h1234,
                              32'h2, 32'h1, 32'h00F0000F, 32'h21, 32'h4,
                              32'hFF00FF00, 32'hFF00FF00, 32'hFFFFFFFF};
    logic [31:0] ve  [13] = '{32'h1, 32'h0, 32'hF8000000, 32'h08000000, 32'h12340000,
                              32'h1, 32'hFFFFFFFF, 32'hF000FFF0, 32'h2, 32'h04000000,
                              32'hF000F000, 32'h0FF00FF0, 32'h0};
    for (int i = 0; i < 13; i++) begin
      ALUop = ops[i]; A = va[i]; B = vb[i];
      #1;
      checks++;
      if (Out !== ve[i]) begin
        errors++;
        $display("FAIL alu_vec%0d op=%0d: got %h want %h", i, ops[i], Out, ve[i]);
      end
    end
    ALUop = ALU_ADDU;
  endtask

  task automatic test_mult();
    int edges; bit low_ok;
    run_op(MD_MULT, 32'hFFFFFFFD, 32'h7, edges, low_ok);
    checks++; if (edges !== 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", edges); end
    checks++; if (!low_ok) begin errors++; $display("FAIL mult_ready_low: ready rose before done"); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL mult_ready_at_done: got %b want 1", md_ready); end
    @(posedge clk); #1;
    checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b want 0", md_done); end
    run_op(MD_MULTU, 32'hFFFFFFFD, 32'h7, edges, low_ok);
    checks++; if (edges !== 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", edges); end
    checks++; if (hi !== 32'h00000006) begin errors++; $display("FAIL multu_hi: got %h want 00000006", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL multu_lo: got %h want ffffffeb", lo); end
  endtask

  task automatic test_div();
    logic [2:0]  ops [6] = '{MD_DIV, MD_DIVU, MD_DIVU, MD_DIV, MD_DIV, MD_DIV};
    logic [31:0] va  [6] = '{32'hFFFFFFF9, 32'h7, 32'h55, 32'h80000000, 32'h7, 32'hFFFFFFFB};
    logic [31:0] vb  [6] = '{32'h2, 32'h2, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0};
    logic [31:0] elo [6] = '{32'hFFFFFFFD, 32'h3, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFF};
    logic [31:0] ehi [6] = '{32'hFFFFFFFF, 32'h1, 32'h55, 32'h0, 32'h1, 32'hFFFFFFFB};
    int edges; bit low_ok;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], va[i], vb[i], edges, low_ok);
      checks++;
      if (edges !== 33 || lo !== elo[i] || hi !== ehi[i]) begin
        errors++;
        $display("FAIL div_vec%0d: edges %0d lo %h hi %h want 33 %h %h", i, edges, lo, hi, elo[i], ehi[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    bit got = 1'b0;
    @(negedge clk); md_op = MD_MTLO; A = 32'h00005A5A; md_valid = 1'b1;
    @(negedge clk); md_op = MD_MULTU; A = 32'hFFFFFFFD; B = 32'h7;
    @(negedge clk); md_op = MD_MTLO; A = 32'h00001111;
    repeat (3) @(negedge clk);
    md_valid = 1'b0;
    checks++; if (lo !== 32'h00005A5A) begin errors++; $display("FAIL busy_mtlo_ignored: lo %h want 00005a5a", lo); end
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (md_done) begin got = 1'b1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL busy_done_seen: no md_done within bound"); end
    checks++; if (lo !== 32'hFFFFFFEB || hi !== 32'h6) begin errors++; $display("FAIL busy_result: lo %h hi %h want ffffffeb 00000006", lo, hi); end
  endtask

  task automatic test_reset_midop();
    bit seen = 1'b0;
    @(negedge clk); md_op = MD_MULT; A = 32'hFFFFFFFD; B = 32'h7; md_valid = 1'b1;
    @(negedge clk); md_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rst_mid_hilo: hi %h lo %h want 0 0", hi, lo); end
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", md_ready); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (md_done) seen = 1'b1;
    end
    checks++; if (seen || hi !== 32'h0) begin errors++; $display("FAIL rst_mid_no_done: done_seen %b hi %h want 0 0", seen, hi); end
  endtask

  task automatic test_back_to_back();
    int edges; bit low_ok;
    run_op(MD_MULT, 32'hFFFFFFFD, 32'h7, edges, low_ok);
    md_op = MD_MTHI; A = 32'h0000ABCD; md_valid = 1'b1;
    checks++; if (md_ready !== 1'b1 || edges !== 33) begin errors++; $display("FAIL b2b_ready: ready %b edges %0d want 1 33", md_ready, edges); end
    @(posedge clk); #1;
    md_valid = 1'b0;
    checks++; if (hi !== 32'h0000ABCD) begin errors++; $display("FAIL b2b_mthi: hi %h want 0000abcd", hi); end
    checks++; if (lo !== 32'hFFFFFFEB || md_done !== 1'b0 || md_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_state: lo %h done %b ready %b want ffffffeb 0 1", lo, md_done, md_ready);
    end
  endtask

  task automatic test_unused_op();
    bit seen = 1'b0; bit busy = 1'b0;
    @(negedge clk); md_op = 3'd6; A = 32'h1234; B = 32'h5; md_valid = 1'b1;
    @(negedge clk); md_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (md_done) seen = 1'b1;
      if (!md_ready) busy = 1'b1;
    end
    checks++; if (seen || busy) begin errors++; $display("FAIL unused_op: done_seen %b busy %b want 0 0", seen, busy); end
    checks++; if (hi !== 32'h0000ABCD || lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL unused_op_hilo: hi %h lo %h want 0000abcd ffffffeb", hi, lo); end
  endtask

  task automatic test_width16();
    int edges;
    alu16 = ALU_LUI; b16 = 16'h0012; #1;
    checks++; if (out16 !== 16'h1200) begin errors++; $display("FAIL w16_lui: got %h want 1200", out16); end
    run_op16(MD_MULTU, 16'hFFFF, 16'hFFFF, edges);
    checks++; if (edges !== 17) begin errors++; $display("FAIL w16_latency: got %0d want 17", edges); end
    checks++; if (hi16 !== 16'hFFFE || lo16 !== 16'h0001) begin errors++; $display("FAIL w16_multu: hi %h lo %h want fffe 0001", hi16, lo16); end
    run_op16(MD_DIV, 16'hFFF9, 16'h0002, edges);
    checks++; if (edges !== 17 || lo16 !== 16'hFFFD || hi16 !== 16'hFFFF) begin
      errors++; $display("FAIL w16_div: edges %0d lo %h hi %h want 17 fffd ffff", edges, lo16, hi16);
    end
  endtask

  initial begin
    A = '0; B = '0; ALUop = ALU_ADDU; md_op = MD_MULT; md_valid = 1'b0;
    a16 = '0; b16 = '0; alu16 = ALU_ADDU; op16 = MD_MULT; valid16 = 1'b0;
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_busy_ignore();
    test_reset_midop();
    test_mult();
    test_back_to_back();
    test_unused_op();
    test_width16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised next-generation MIPS150 execute unit: single-cycle combinational ALU plus a multi-cycle iterative multiply/divide unit with architectural HI/LO registers.
- Supports MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Corrects signed SLT and arithmetic SRA semantics.
- Sits in the EX stage; the pipeline control stalls on md_ready.

Parameters:
- WIDTH, 32, datapath width. Must be even and ≥ 8.
- SHAMT_W, $clog2(WIDTH), number of shift-amount bits taken from B.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- A  in  WIDTH  operand A (rs).
- B  in  WIDTH  operand B (rt, immediate or shamt).
- ALUop  in  4  combinational ALU operation, existing ALU_* encodings.
- Out  out  WIDTH  combinational ALU result.
- md_op  in  3  mul/div operation code (MD_* encodings).
- md_valid  in  1  request strobe for md_op with operands A and B.
- md_ready  out  1  high when the unit can accept a request.
- md_done  out  1  one-cycle pulse when a MULT/DIV result lands in HI/LO.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Clocking: one clock, clk. Reset rst is asynchronous and active-high.
- Combinational ALU, no clock dependence:
  - ADDU/SUBU wrap modulo 2^WIDTH.
  - SLT compares A and B signed; SLTU compares unsigned. Result is 1 or 0, zero-extended to WIDTH.
  - AND, OR, XOR, NOR are bitwise.
  - SLL computes A << B[SHAMT_W-1:0]. SRL shifts right and fills with zeros. SRA shifts right and fills with A[WIDTH-1].
  - LUI computes B << (WIDTH/2).
  - Undefined ALUop drives Out to 0 (no X).
- Reset: hi = 0, lo = 0, md_ready = 1, md_done = 0, FSM = IDLE. Applies immediately, including mid-operation; any in-flight result is discarded.
- Handshake: a request is accepted on a rising edge where md_valid & md_ready. md_valid while md_ready = 0 is ignored; there is no queueing.
- MTHI/MTLO: on the accepting edge, hi ← A (MTHI) or lo ← A (MTLO). md_ready stays 1 and md_done stays 0.
- FSM states and transitions:
  - IDLE → on MULT/MULTU/DIV/DIVU accept, latch operand magnitudes and the signed flag, counter ← 0, go to BUSY.
  - BUSY → one shift-add (multiply) or restoring-subtract (divide) step per cycle; counter increments. After WIDTH steps, go to FIX.
  - FIX → apply sign correction and write HI/LO, assert md_done for one cycle, go to IDLE.
- Timing:
  - md_ready falls on the accepting edge.
  - hi/lo update and md_done rise exactly WIDTH+1 edges after the accepting edge.
  - md_ready returns to 1 in that same cycle, so back-to-back issue is legal.
- Arithmetic rules:
  - MULT/MULTU: {hi, lo} = full 2·WIDTH-bit product; MULT signed, MULTU unsigned.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero (both variants): lo = all ones, hi = A. No exception is raised.
  - Signed DIV of most-negative by -1: lo = most-negative, hi = 0.
- hi/lo hold their value between writes and are readable every cycle.
- Unused md_op codes are accepted and act as no-ops: no state change, no md_done.

Decomposition:
- ALUop.vh keeps the ALU_* encodings.
- New MDop.vh holds MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
- FSM state localparams stay local to the sequential block.
- Sub-module muldiv_seq holds the FSM, counter and HI/LO.
- The top-level alu_muldiv contains the combinational ALU and instantiates muldiv_seq.

Test Plan:
- Combinational ALU, WIDTH=32:
  - A=0xFFFFFFFF, B=1: SLT → 1; SLTU → 0.
  - A=0x80000000, B=4: SRA → 0xF8000000; SRL → 0x08000000.
  - B=0x1234 with LUI → 0x12340000.
- MULT, A=-3 (0xFFFFFFFD), B=7: hi=0xFFFFFFFF, lo=0xFFFFFFEB, md_done exactly 33 edges after accept; md_ready low in between. MULTU with the same operands: hi=0x00000006, lo=0xFFFFFFEB.
- DIV, A=-7, B=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU, A=7, B=2: lo=3, hi=1.
- DIVU, A=0x55, B=0: lo=0xFFFFFFFF, hi=0x55. DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- Handshake and reset:
  - Assert md_valid with MTLO while BUSY → ignored; lo unchanged at done.
  - Assert rst at cycle 10 of a MULT → hi=lo=0, md_ready=1 immediately, no md_done.
  - Issue MTHI A=0xABCD in the md_done cycle → accepted, hi=0xABCD next edge.
- Parametric: WIDTH=16, MULTU 0xFFFF×0xFFFF → hi=0xFFFE, lo=0x0001, done 17 edges after accept.
